rv32i_dmemarbiter: RTL and testbench
====================================

# rv32i_dmemArbiter

Two-port arbiter and sequencer for the data memory banks (4K-word bank at 0x8000–0xBFFF, 2K-word bank at 0xC000–0xDFFF). It shares the single-ported banks between the CPU load/store port and the program-loader/debug port. Per transaction it decodes the address, generates per-byte write enables and lane-shifted write data for SB/SH/SW, sequences the synchronous-read RAM, and returns the read word with an ack/err handshake.

## Interface
Parameters:
- BANK4K_TAG, 18'h00002, match value for addr[31:14] selecting the 4K bank
- BANK2K_TAG, 19'h00006, match value for addr[31:13] selecting the 2K bank

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req / ldr_req  in  1  transaction request; held high with fields stable until the matching ack
- cpu_we / ldr_we  in  1  1 = store, 0 = load
- cpu_funct3 / ldr_funct3  in  3  store width: 000 SB, 001 SH, 010 SW; ignored for loads
- cpu_addr / ldr_addr  in  32  byte address
- cpu_wdata / ldr_wdata  in  32  store data, right-aligned
- cpu_ack / ldr_ack  out  1  one-cycle completion pulse
- cpu_err / ldr_err  out  1  valid with ack; 1 = access rejected, no write performed
- cpu_rdata / ldr_rdata  out  32  raw read word, valid with ack (loads only, else 0)
- ram4k_addr  out  12  word index, addr[13:2]
- ram4k_we  out  4  byte write enables, 4K bank
- ram2k_addr  out  11  word index, addr[12:2]
- ram2k_we  out  4  byte write enables, 2K bank
- ram_wdata  out  32  lane-shifted write data, shared by both banks
- ram4k_rdata / ram2k_rdata  in  32  synchronous-read data, valid one cycle after the address

## Operation
- FSM states: IDLE → ACCESS → RESP → IDLE. No other transitions except reset.
- IDLE: if any req is high, pick the winner, latch its we/funct3/addr/wdata, latch the bank hit, and go to ACCESS. Otherwise stay in IDLE.
- Bank hit: 4K when addr[31:14]==BANK4K_TAG; 2K when addr[31:13]==BANK2K_TAG; otherwise none.
- Lane decode for stores:
  - SB: we = 0001/0010/0100/1000 for addr[1:0] = 0/1/2/3; data = wdata[7:0] placed in the selected lane.
  - SH: addr[1:0]=00 gives 0011 and {16'h0, wdata[15:0]}; addr[1:0]=10 gives 1100 and {wdata[15:0], 16'h0}; odd addresses are misaligned.
  - SW: 1111 with data unchanged; addr[1:0] ignored.
- Error (err=1, all RAM write enables 0, rdata=0): no bank hit, a misaligned SH, or a store with funct3 not in {000, 001, 010}. Loads error only on no bank hit.
- ACCESS: drive the latched word index onto the hit bank's address. Drive we for exactly this one cycle, only when there is no error.
- RESP: pulse ack to the granted port. For a load, rdata is the read data of the latched bank. The non-granted port's ack/err/rdata stay 0.
- All RAM outputs are registered. The address holds its last value outside ACCESS. WE and ram_wdata are 0 outside ACCESS.

## Timing
- Request sampled in IDLE at edge T. ACCESS is cycle T+1, RESP (ack) is cycle T+2, IDLE is cycle T+3.
- Transaction occupancy is 3 cycles; peak throughput is one access per 3 cycles.
- A req still high in IDLE after an ack is treated as a new transaction. The requester drops req, or presents new fields, in the cycle after it sees ack.
- Simultaneous requests: resolved per Configuration. A loser keeps req high and is served on the next IDLE.
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - All outputs go to 0 immediately: acks, errs, rdatas, WEs, addresses, ram_wdata.
  - The last-grant register is set to ldr.
  - An in-flight transaction is dropped with no ack; a store in ACCESS is cut short.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin. On contention, the port not granted last wins. The last-grant register updates on each grant.
- DMEM_ARB_RR_EN undefined: fixed priority. cpu always beats ldr, and the last-grant register is not implemented.

## Test plan
- CPU SW 0xDEADBEEF to 0x8004 → at T+1, ram4k_addr=1, ram4k_we=1111, ram_wdata=0xDEADBEEF; cpu_ack=1, cpu_err=0 at T+2.
- ldr SB 0x000000AB to 0xC003 → ram2k_addr=0, ram2k_we=1000, ram_wdata=0xAB000000; following load of 0xC000 returns 0xAB000000 in ldr_rdata.
- CPU SH to 0x8001 and SW to 0x4000 → ack with cpu_err=1 on each; ram4k_we and ram2k_we stay 0000 throughout.
- Both ports request loads continuously for 4 transactions → RR_EN: grants cpu, ldr, cpu, ldr; without the macro: cpu every time while its req is held.
- rst_n low during ACCESS of a store → WE drops to 0 asynchronously, no ack; after release, FSM is in IDLE and the first contended grant goes to cpu.

Source files
------------

// File: rtl/rv32i_dmemarbiter.sv
// Two-port (cpu / loader) arbiter and sequencer for the 4K-word and 2K-word data banks.
// Optional round-robin arbitration when DMEM_ARB_RR_EN is defined; fixed cpu priority otherwise.
module rv32i_dmemarbiter #(
  parameter logic [17:0] BANK4K_TAG = 18'h00002,
  parameter logic [18:0] BANK2K_TAG = 19'h00006
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_funct3,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [2:0]  ldr_funct3,
  input  logic [31:0] ldr_addr,
  input  logic [31:0] ldr_wdata,
  output logic        ldr_ack,
  output logic        ldr_err,
  output logic [31:0] ldr_rdata,
  output logic [11:0] ram4k_addr,
  output logic [3:0]  ram4k_we,
  output logic [10:0] ram2k_addr,
  output logic [3:0]  ram2k_we,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram4k_rdata,
  input  logic [31:0] ram2k_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;

  logic        grant_ldr;
  logic        sel_we;
  logic [2:0]  sel_f3;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        hit4k, hit2k;
  logic [3:0]  lane_be;
  logic [31:0] lane_data;
  logic        bad_store;
  logic        sel_err;
  logic        store_ok;

  logic        resp_ldr;
  logic        resp_err;
  logic        resp_load;
  logic        resp_4k;
  logic [31:0] resp_rdata;

`ifdef DMEM_ARB_RR_EN
  logic last_ldr;

  always_comb begin
    grant_ldr = ldr_req && (!cpu_req || !last_ldr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ldr <= 1'b1;
    end else if (state == IDLE && (cpu_req || ldr_req)) begin
      last_ldr <= grant_ldr;
    end
  end
`else
  always_comb begin
    grant_ldr = ldr_req && !cpu_req;
  end
`endif

  always_comb begin
    sel_we    = grant_ldr ? ldr_we     : cpu_we;
    sel_f3    = grant_ldr ? ldr_funct3 : cpu_funct3;
    sel_addr  = grant_ldr ? ldr_addr   : cpu_addr;
    sel_wdata = grant_ldr ? ldr_wdata  : cpu_wdata;
    hit4k     = (sel_addr[31:14] == BANK4K_TAG);
    hit2k     = (sel_addr[31:13] == BANK2K_TAG);
  end

  always_comb begin
    lane_be   = '0;
    lane_data = '0;
    bad_store = 1'b0;
    case (sel_f3)
      3'b000: begin
        lane_be   = 4'b0001 << sel_addr[1:0];
        lane_data = {24'h0, sel_wdata[7:0]} << {sel_addr[1:0], 3'b000};
      end
      3'b001: begin
        if (sel_addr[0]) begin
          bad_store = 1'b1;
        end else if (sel_addr[1]) begin
          lane_be   = 4'b1100;
          lane_data = {sel_wdata[15:0], 16'h0};
        end else begin
          lane_be   = 4'b0011;
          lane_data = {16'h0, sel_wdata[15:0]};
        end
      end
      3'b010: begin
        lane_be   = 4'b1111;
        lane_data = sel_wdata;
      end
      default: bad_store = 1'b1;
    endcase
    sel_err  = !(hit4k || hit2k) || (sel_we && bad_store);
    store_ok = sel_we && !sel_err;
  end

  // The request is decoded at grant time and only the decoded results are kept;
  // this lets the RAM address/we/wdata registers be valid throughout ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_ldr   <= 1'b0;
      resp_err   <= 1'b0;
      resp_load  <= 1'b0;
      resp_4k    <= 1'b0;
      ram4k_addr <= '0;
      ram2k_addr <= '0;
      ram4k_we   <= '0;
      ram2k_we   <= '0;
      ram_wdata  <= '0;
      cpu_ack    <= 1'b0;
      cpu_err    <= 1'b0;
      ldr_ack    <= 1'b0;
      ldr_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || ldr_req) begin
            state     <= ACCESS;
            resp_ldr  <= grant_ldr;
            resp_err  <= sel_err;
            resp_load <= !sel_we;
            resp_4k   <= hit4k;
            if (hit4k) ram4k_addr <= sel_addr[13:2];
            if (hit2k) ram2k_addr <= sel_addr[12:2];
            ram4k_we  <= (store_ok && hit4k) ? lane_be : '0;
            ram2k_we  <= (store_ok && hit2k) ? lane_be : '0;
            ram_wdata <= store_ok ? lane_data : '0;
          end
        end
        ACCESS: begin
          state     <= RESP;
          ram4k_we  <= '0;
          ram2k_we  <= '0;
          ram_wdata <= '0;
          cpu_ack   <= !resp_ldr;
          cpu_err   <= !resp_ldr && resp_err;
          ldr_ack   <= resp_ldr;
          ldr_err   <= resp_ldr && resp_err;
        end
        RESP: begin
          state   <= IDLE;
          cpu_ack <= 1'b0;
          cpu_err <= 1'b0;
          ldr_ack <= 1'b0;
          ldr_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Synchronous-read data arrives during RESP, so it is steered combinationally behind the registered ack.
  always_comb begin
    resp_rdata = resp_4k ? ram4k_rdata : ram2k_rdata;
    cpu_rdata  = (cpu_ack && resp_load && !resp_err) ? resp_rdata : '0;
    ldr_rdata  = (ldr_ack && resp_load && !resp_err) ? resp_rdata : '0;
  end

endmodule

// File: tb/tb_rv32i_dmemarbiter.sv
// Bench for rv32i_dmemarbiter: directed vector table, contention and reset sequences,
// and randomized transactions checked against an address-range/byte-lane memory model.
module tb_rv32i_dmemarbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [2:0]  cpu_funct3 = '0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        ldr_req = 1'b0, ldr_we = 1'b0;
  logic [2:0]  ldr_funct3 = '0;
  logic [31:0] ldr_addr = '0, ldr_wdata = '0;
  logic        cpu_ack, cpu_err, ldr_ack, ldr_err;
  logic [31:0] cpu_rdata, ldr_rdata;
  logic [11:0] ram4k_addr;
  logic [10:0] ram2k_addr;
  logic [3:0]  ram4k_we, ram2k_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram4k_rdata = '0, ram2k_rdata = '0;

  logic [31:0] ram4k [4096] = '{default: '0};
  logic [31:0] ram2k [2048] = '{default: '0};
  logic [31:0] shadow4k [4096] = '{default: '0};
  logic [31:0] shadow2k [2048] = '{default: '0};

  int n_pass = 0;
  int n_total = 0;

  rv32i_dmemarbiter #(.BANK4K_TAG(18'h00002), .BANK2K_TAG(19'h00006)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_funct3(ldr_funct3), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack), .ldr_err(ldr_err), .ldr_rdata(ldr_rdata),
    .ram4k_addr(ram4k_addr), .ram4k_we(ram4k_we), .ram2k_addr(ram2k_addr), .ram2k_we(ram2k_we),
    .ram_wdata(ram_wdata), .ram4k_rdata(ram4k_rdata), .ram2k_rdata(ram2k_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read, byte-writable RAM banks.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram4k_we[b]) ram4k[ram4k_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      if (ram2k_we[b]) ram2k[ram2k_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram4k_rdata <= ram4k[ram4k_addr];
    ram2k_rdata <= ram2k[ram2k_addr];
  end

  typedef struct {
    bit          port;   // 0 cpu, 1 ldr
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          bank;   // 0 none, 1 4K, 2 2K
    int          idx;
    logic [3:0]  be;
    logic [31:0] dat;
    bit          err;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(bit port, bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                              int bank, int idx, logic [3:0] be, logic [31:0] dat, bit err,
                              logic [31:0] rd);
    vec_t v;
    v.port = port; v.we = we; v.f3 = f3; v.addr = a; v.wd = wd;
    v.bank = bank; v.idx = idx; v.be = be; v.dat = dat; v.err = err; v.rd = rd;
    return v;
  endfunction

  // Reference: bank by address range, lanes by byte size and offset, load data from shadow memory.
  function automatic vec_t ref_model(bit port, bit we, logic [2:0] f3, logic [31:0] a,
                                     logic [31:0] wd);
    vec_t v;
    int sz;
    int off;
    longint unsigned mask;
    v.port = port; v.we = we; v.f3 = f3; v.addr = a; v.wd = wd;
    v.bank = 0; v.idx = 0; v.be = '0; v.dat = '0; v.rd = '0;
    if (a >= 32'h8000 && a <= 32'hBFFF) begin
      v.bank = 1; v.idx = int'((a - 32'h8000) / 4);
    end else if (a >= 32'hC000 && a <= 32'hDFFF) begin
      v.bank = 2; v.idx = int'((a - 32'hC000) / 4);
    end
    case (f3)
      3'd0: sz = 1;
      3'd1: sz = 2;
      3'd2: sz = 4;
      default: sz = 0;
    endcase
    off = int'(a % 4);
    if (sz == 4) off = 0;
    v.err = (v.bank == 0) || (we && (sz == 0 || (sz == 2 && off % 2 != 0)));
    if (we && !v.err) begin
      mask  = (64'd1 << (8 * sz)) - 1;
      v.be  = 4'(((1 << sz) - 1) << off);
      v.dat = 32'((longint'(wd) & mask) << (8 * off));
    end
    if (!we && !v.err) v.rd = (v.bank == 1) ? shadow4k[v.idx] : shadow2k[v.idx];
    return v;
  endfunction

  task automatic drive(input bit port, input bit req, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    if (port) begin
      ldr_req = req; ldr_we = we; ldr_funct3 = f3; ldr_addr = a; ldr_wdata = wd;
    end else begin
      cpu_req = req; cpu_we = we; cpu_funct3 = f3; cpu_addr = a; cpu_wdata = wd;
    end
  endtask

  task automatic txn(input vec_t v);
    @(negedge clk);
    drive(v.port, 1'b1, v.we, v.f3, v.addr, v.wd);
    @(posedge clk); #1;
    chk("access_no_ack", 32'({cpu_ack, ldr_ack}), 32'd0);
    chk("we4k", 32'(ram4k_we), 32'((v.bank == 1) ? v.be : 4'h0));
    chk("we2k", 32'(ram2k_we), 32'((v.bank == 2) ? v.be : 4'h0));
    chk("wdata", ram_wdata, v.dat);
    if (v.bank == 1) chk("addr4k", 32'(ram4k_addr), 32'(v.idx));
    if (v.bank == 2) chk("addr2k", 32'(ram2k_addr), 32'(v.idx));
    @(posedge clk); #1;
    drive(v.port, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    chk("ack", 32'(v.port ? ldr_ack : cpu_ack), 32'd1);
    chk("other_ack", 32'(v.port ? cpu_ack : ldr_ack), 32'd0);
    chk("err", 32'(v.port ? ldr_err : cpu_err), 32'(v.err));
    chk("rdata", v.port ? ldr_rdata : cpu_rdata, v.rd);
    chk("other_rdata", v.port ? cpu_rdata : ldr_rdata, 32'd0);
    chk("resp_we", 32'({ram4k_we, ram2k_we}), 32'd0);
    if (v.we && !v.err) begin
      for (int b = 0; b < 4; b++) begin
        if (v.be[b] && v.bank == 1) shadow4k[v.idx][8*b +: 8] = v.dat[8*b +: 8];
        if (v.be[b] && v.bank == 2) shadow2k[v.idx][8*b +: 8] = v.dat[8*b +: 8];
      end
    end
    @(posedge clk); #1;
    chk("ack_pulse", 32'({cpu_ack, ldr_ack}), 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2, 3: return 32'h8000 + 32'($urandom_range(0, 63));
      4:          return 32'hBFF0 + 32'($urandom_range(0, 15));
      5, 6, 7:    return 32'hC000 + 32'($urandom_range(0, 63));
      8:          return 32'hDFF0 + 32'($urandom_range(0, 31));
      default:    return $urandom();
    endcase
  endfunction

  initial begin
    vec_t v;
    vec_t ec, el;
    int got, cyc, last;
    bit exp_ldr, seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acks", 32'({cpu_ack, ldr_ack, cpu_err, ldr_err}), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_ldr_rdata", ldr_rdata, 32'd0);
    chk("rst_we", 32'({ram4k_we, ram2k_we}), 32'd0);
    chk("rst_addr", 32'({ram4k_addr, ram2k_addr}), 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors; memories start at zero
    tbl.push_back(mk(0, 1, 3'd2, 32'h8004, 32'hDEADBEEF, 1, 1,     4'hF, 32'hDEADBEEF, 0, 32'h0));
    tbl.push_back(mk(1, 1, 3'd0, 32'hC003, 32'h000000AB, 2, 0,     4'h8, 32'hAB000000, 0, 32'h0));
    tbl.push_back(mk(1, 0, 3'd2, 32'hC000, 32'h0,        2, 0,     4'h0, 32'h0,        0, 32'hAB000000));
    tbl.push_back(mk(0, 1, 3'd1, 32'h8001, 32'h00001234, 1, 0,     4'h0, 32'h0,        1, 32'h0));
    tbl.push_back(mk(0, 1, 3'd2, 32'h4000, 32'h12345678, 0, 0,     4'h0, 32'h0,        1, 32'h0));
    tbl.push_back(mk(0, 0, 3'd2, 32'h8004, 32'h0,        1, 1,     4'h0, 32'h0,        0, 32'hDEADBEEF));
    tbl.push_back(mk(0, 1, 3'd1, 32'h8006, 32'h12345678, 1, 1,     4'hC, 32'h56780000, 0, 32'h0));
    tbl.push_back(mk(0, 0, 3'd2, 32'h8004, 32'h0,        1, 1,     4'h0, 32'h0,        0, 32'h5678BEEF));
    tbl.push_back(mk(1, 1, 3'd0, 32'h8005, 32'h000000FF, 1, 1,     4'h2, 32'h0000FF00, 0, 32'h0));
    tbl.push_back(mk(0, 0, 3'd7, 32'h8007, 32'h0,        1, 1,     4'h0, 32'h0,        0, 32'h5678FFEF));
    tbl.push_back(mk(0, 1, 3'd3, 32'h8008, 32'hFFFFFFFF, 1, 2,     4'h0, 32'h0,        1, 32'h0));
    tbl.push_back(mk(1, 1, 3'd2, 32'hDFFE, 32'hCAFEF00D, 2, 2047,  4'hF, 32'hCAFEF00D, 0, 32'h0));
    tbl.push_back(mk(0, 0, 3'd2, 32'hDFFC, 32'h0,        2, 2047,  4'h0, 32'h0,        0, 32'hCAFEF00D));
    tbl.push_back(mk(0, 0, 3'd2, 32'hE000, 32'h0,        0, 0,     4'h0, 32'h0,        1, 32'h0));
    tbl.push_back(mk(0, 0, 3'd2, 32'hBFFC, 32'h0,        1, 4095,  4'h0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 1, 3'd1, 32'hC002, 32'hAAAABBBB, 2, 0,     4'hC, 32'hBBBB0000, 0, 32'h0));
    tbl.push_back(mk(1, 0, 3'd0, 32'hC001, 32'h0,        2, 0,     4'h0, 32'h0,        0, 32'hBBBB0000));
    tbl.push_back(mk(0, 1, 3'd0, 32'h7FFF, 32'h00000011, 0, 0,     4'h0, 32'h0,        1, 32'h0));
    tbl.push_back(mk(0, 1, 3'd1, 32'h8003, 32'h00002222, 1, 0,     4'h0, 32'h0,        1, 32'h0));
    tbl.push_back(mk(1, 1, 3'd0, 32'hBFFE, 32'h0000005A, 1, 4095,  4'h4, 32'h005A0000, 0, 32'h0));
    foreach (tbl[i]) txn(tbl[i]);

    // Both ports hold load requests for four transactions
    ec = ref_model(0, 0, 3'd2, 32'h8004, 32'h0);
    el = ref_model(1, 0, 3'd2, 32'hC000, 32'h0);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 3'd2, 32'h8004, 32'h0);
    drive(1, 1'b1, 1'b0, 3'd2, 32'hC000, 32'h0);
    got = 0; cyc = 0; last = 0;
    while (got < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cpu_ack || ldr_ack) begin
`ifdef DMEM_ARB_RR_EN
        exp_ldr = (got % 2 == 1);
`else
        exp_ldr = 1'b0;
`endif
        chk("cont_single_ack", 32'(cpu_ack & ldr_ack), 32'd0);
        chk("cont_grant", 32'(ldr_ack), 32'(exp_ldr));
        chk("cont_rdata", ldr_ack ? ldr_rdata : cpu_rdata, ldr_ack ? el.rd : ec.rd);
        if (got > 0) chk("cont_spacing", 32'(cyc - last), 32'd3);
        last = cyc;
        got++;
        if (got == 4) begin
          drive(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
          drive(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        end
      end
    end
    chk("cont_done", 32'(got), 32'd4);
    drive(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);

    // Randomized single-port transactions
    for (int i = 0; i < 200; i++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 3) == 3) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      v = ref_model(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f3, rand_addr(), $urandom());
      txn(v);
    end

    // Reset asserted while a store is in ACCESS
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 3'd2, 32'h8010, 32'h11112222);
    @(posedge clk); #1;
    chk("cut_we_before", 32'(ram4k_we), 32'hF);
    #1 rst_n = 1'b0;
    #1;
    chk("cut_we_async", 32'({ram4k_we, ram2k_we}), 32'd0);
    chk("cut_wdata_async", ram_wdata, 32'd0);
    chk("cut_addr_async", 32'({ram4k_addr, ram2k_addr}), 32'd0);
    drive(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("cut_no_ack", 32'({cpu_ack, ldr_ack}), 32'd0);
    end

    // First contended grant after reset goes to cpu; cut store left memory untouched
    ec = ref_model(0, 0, 3'd2, 32'h8010, 32'h0);
    el = ref_model(1, 0, 3'd2, 32'hC004, 32'h0);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 3'd2, 32'h8010, 32'h0);
    drive(1, 1'b1, 1'b0, 3'd2, 32'hC004, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (cpu_ack || ldr_ack) begin
        seen = 1'b1;
        chk("post_rst_grant", 32'(ldr_ack), 32'd0);
        chk("post_rst_rdata", cpu_rdata, ec.rd);
        drive(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      end
    end
    chk("post_rst_ack_seen", 32'(seen), 32'd1);
    drive(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (ldr_ack) begin
        seen = 1'b1;
        chk("post_rst_ldr_rdata", ldr_rdata, el.rd);
        drive(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      end
    end
    chk("post_rst_ldr_seen", 32'(seen), 32'd1);
    drive(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
